// File: rtl/start_screen_pkg.sv
// Shared types and constants for the start-screen pixel stage.
package start_screen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_TITLE = 2'd0;
    localparam state_t S_PRESS = 2'd1;
    localparam state_t S_GO    = 2'd2;
    localparam state_t S_RUN   = 2'd3;

    localparam int COORD_W = 11;
    localparam logic [COORD_W-1:0] WIN_W      = 11'd256;
    localparam logic [COORD_W-1:0] WIN_H      = 11'd64;
    localparam logic [COORD_W-1:0] PROMPT_ROW = 11'd48;

    localparam int ROM_AW = 14;
    localparam logic [7:0] BLACK = 8'h00;

    // Title image: even parity of the masked address marks a lit pixel.
    localparam logic [ROM_AW-1:0] GLYPH_MASK = 14'h1C63;

    function automatic logic title_glyph(input logic [ROM_AW-1:0] addr);
        return ~(^(addr & GLYPH_MASK));
    endfunction

endpackage

// File: rtl/start_title_rom.sv
// 16384x1 title bitmap with a registered (synchronous) read port.
module start_title_rom
    import start_screen_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr_i,
    output logic              data_o
);

    logic data_q;

    // Contents are fixed at elaboration by title_glyph().
    always_ff @(posedge clk) begin
        data_q <= title_glyph(addr_i);
    end

    assign data_o = data_q;

endmodule

// File: rtl/start_screen_pixel_module.sv
// Start-screen pixel stage: bitmap lookup, blinking prompt, key debounce
// and the title/run handoff FSM.
module start_screen_pixel_module
    import start_screen_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         BLINK_FRAMES    = 32,
    parameter logic [7:0] TEXT_COLOR      = 8'hFC,
    parameter logic [7:0] BG_COLOR        = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] col_addr,
    input  logic [10:0] row_addr,
    input  logic        disp_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        key_n,
    input  logic        game_over,
    output logic [7:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        start_pulse,
    output logic        game_active
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCW-1:0] FRM_LAST = FCW'(BLINK_FRAMES - 1);

    // ---------------- pixel stage 1: ROM read + side-band ----------------
    logic rom_bit;
    logic win_q, prompt_q, den_q, hs_q, vs_q;

    start_title_rom u_rom (
        .clk    (clk),
        .addr_i ({row_addr[5:0], col_addr[7:0]}),
        .data_o (rom_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= 1'b0;
            prompt_q <= 1'b0;
            den_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            win_q    <= (col_addr < WIN_W) && (row_addr < WIN_H);
            prompt_q <= (row_addr >= PROMPT_ROW);
            den_q    <= disp_en;
            hs_q     <= hsync_in;
            vs_q     <= vsync_in;
        end
    end

    // ---------------- blink: frame counter on vsync rising edge ----------
    logic           vs_prev_q;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           blink_on_q, blink_on_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (vsync_in && !vs_prev_q) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            vs_prev_q   <= vsync_in;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // ---------------- key synchronizer + debounce ------------------------
    logic           key_s1_q, key_s2_q;
    logic           key_stable_q, key_stable_d;
    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic           key_accept, key_fall, key_rise;

    always_comb begin
        key_stable_d = key_stable_q;
        deb_cnt_d    = '0;
        key_accept   = (key_s2_q != key_stable_q) && (deb_cnt_q == DEB_LAST);
        if (key_accept) begin
            key_stable_d = key_s2_q;
        end else if (key_s2_q != key_stable_q) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign key_fall = key_accept && !key_s2_q;
    assign key_rise = key_accept &&  key_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            key_stable_q <= 1'b1;
            deb_cnt_q    <= '0;
        end else begin
            key_s1_q     <= key_n;
            key_s2_q     <= key_s1_q;
            key_stable_q <= key_stable_d;
            deb_cnt_q    <= deb_cnt_d;
        end
    end

    // ---------------- title/run FSM: start commits on key release --------
    state_t state_q, state_d;
    logic   start_pulse_q, game_active_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TITLE: if (key_fall)  state_d = S_PRESS;
            S_PRESS: if (key_rise)  state_d = S_GO;
            S_GO:                   state_d = S_RUN;
            S_RUN:   if (game_over) state_d = S_TITLE;
            default:                state_d = S_TITLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_TITLE;
            start_pulse_q <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_pulse_q <= (state_q == S_GO);
            game_active_q <= (state_q == S_RUN);
        end
    end

    // ---------------- pixel stage 2: colour select + aligned syncs -------
    logic [7:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q;

    always_comb begin
        rgb_d = BG_COLOR;
        if ((state_q == S_RUN) || !den_q) begin
            rgb_d = BLACK;
        end else if (win_q && rom_bit && !(prompt_q && !blink_on_q)) begin
            rgb_d = TEXT_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= BLACK;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hs_q;
            vsync_q <= vs_q;
        end
    end

    assign rgb         = rgb_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign start_pulse = start_pulse_q;
    assign game_active = game_active_q;

endmodule

// File: tb/tb_start_screen_pixel_module.sv
// Randomized bench with a behavioural reference model for the start-screen stage.
module tb_start_screen_pixel_module;

    localparam int         DEB  = 4;
    localparam int         BF   = 2;
    localparam logic [7:0] TXT  = 8'hFC;
    localparam logic [7:0] BGC  = 8'h02;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] col_addr = '0;
    logic [10:0] row_addr = '0;
    logic        disp_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        key_n = 1'b1;
    logic        game_over = 1'b0;
    logic [7:0]  rgb;
    logic        hsync_out, vsync_out, start_pulse, game_active;

    always #20 clk = ~clk;

    start_screen_pixel_module #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_FRAMES    (BF),
        .TEXT_COLOR      (TXT),
        .BG_COLOR        (BGC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .disp_en     (disp_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .key_n       (key_n),
        .game_over   (game_over),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .start_pulse (start_pulse),
        .game_active (game_active)
    );

    int checks = 0;
    int errors = 0;
    int sp_seen = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic        den;
        logic        hs;
        logic        vs;
    } pix_t;

    int         m_state;   // 0 title, 1 key held, 2 go, 3 running
    int         ticks;
    bit         vs_prev;
    bit         kstable;
    int         kq[$];
    pix_t       p0;
    logic [7:0] exp_rgb;
    logic       exp_hs, exp_vs, exp_sp, exp_ga;

    function automatic bit glyph(input int a);
        return ($countones(a & 'h1C63) % 2) == 0;
    endfunction

    function automatic logic [7:0] pixel(input pix_t p, input bit blink, input bit run);
        if (run || !p.den) return 8'h00;
        if (p.col >= 256 || p.row >= 64) return BGC;
        if (p.row >= 48 && !blink) return BGC;
        return glyph(int'({p.row[5:0], p.col[7:0]})) ? TXT : BGC;
    endfunction

    task automatic model_reset();
        m_state = 0;
        ticks   = 0;
        vs_prev = 1'b1;
        kstable = 1'b1;
        kq.delete();
        for (int i = 0; i < DEB + 2; i++) kq.push_back(1);
        p0      = '{col: '0, row: '0, den: 1'b0, hs: 1'b1, vs: 1'b1};
        exp_rgb = 8'h00;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        exp_sp  = 1'b0;
        exp_ga  = 1'b0;
    endtask

    task automatic model_step();
        bit blink, run, flip, fell, rose;
        int n;
        blink   = ((ticks / BF) % 2) == 0;
        run     = (m_state == 3);
        exp_rgb = pixel(p0, blink, run);
        exp_hs  = p0.hs;
        exp_vs  = p0.vs;
        exp_sp  = (m_state == 2);
        exp_ga  = run;
        p0      = '{col: col_addr, row: row_addr, den: disp_en, hs: hsync_in, vs: vsync_in};
        if (vsync_in && !vs_prev) ticks++;
        vs_prev = vsync_in;
        // key level is accepted once it has differed for DEB samples, seen through 2 sync stages
        n    = kq.size();
        flip = 1'b1;
        for (int i = n - 1 - DEB; i <= n - 2; i++)
            if (kq[i] == int'(kstable)) flip = 1'b0;
        fell = 1'b0;
        rose = 1'b0;
        if (flip) begin
            kstable = ~kstable;
            fell = !kstable;
            rose = kstable;
        end
        case (m_state)
            0: if (fell) m_state = 1;
            1: if (rose) m_state = 2;
            2: m_state = 3;
            default: if (game_over) m_state = 0;
        endcase
        kq.push_back(int'(key_n));
        if (kq.size() > DEB + 6) void'(kq.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rgb", rgb, 8'h00);
                chk("rst_hsync", {7'd0, hsync_out}, 8'd1);
                chk("rst_vsync", {7'd0, vsync_out}, 8'd1);
                chk("rst_start_pulse", {7'd0, start_pulse}, 8'd0);
                chk("rst_game_active", {7'd0, game_active}, 8'd0);
            end else begin
                chk("rgb", rgb, exp_rgb);
                chk("hsync_out", {7'd0, hsync_out}, {7'd0, exp_hs});
                chk("vsync_out", {7'd0, vsync_out}, {7'd0, exp_vs});
                chk("start_pulse", {7'd0, start_pulse}, {7'd0, exp_sp});
                chk("game_active", {7'd0, game_active}, {7'd0, exp_ga});
                if (start_pulse) sp_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pix(input logic [10:0] c, input logic [10:0] r, input logic d);
        @(posedge clk); #2;
        col_addr = c;
        row_addr = r;
        disp_en  = d;
    endtask

    task automatic pix_check(input string name, input logic [10:0] c, input logic [10:0] r,
                             input logic d, input logic [7:0] exp);
        set_pix(c, r, d);
        repeat (2) @(posedge clk);
        #1 chk(name, rgb, exp);
    endtask

    task automatic vs_pulse();
        @(posedge clk); #2 vsync_in = 1'b0;
        @(posedge clk); #2 vsync_in = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic key_press(input int low_cycles, input int high_cycles);
        @(posedge clk); #2 key_n = 1'b0;
        repeat (low_cycles) @(posedge clk);
        #2 key_n = 1'b1;
        repeat (high_cycles) @(posedge clk);
    endtask

    task automatic pulse_game_over();
        @(posedge clk); #2 game_over = 1'b1;
        @(posedge clk); #2 game_over = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic random_pixels(input int cycles, input bit with_key);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #2;
            col_addr = 11'($urandom_range(0, 300));
            row_addr = 11'($urandom_range(0, 80));
            disp_en  = ($urandom_range(0, 7) != 0);
            hsync_in = ($urandom_range(0, 5) != 0);
            vsync_in = ($urandom_range(0, 7) != 0);
            if (with_key) key_n = ((i / 12) % 2) == 0;
        end
        @(posedge clk); #2;
        disp_en  = 1'b0;
        col_addr = '0;
        row_addr = '0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        key_n    = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", rgb, 8'h00);
        chk("reset_hsync", {7'd0, hsync_out}, 8'd1);
        chk("reset_vsync", {7'd0, vsync_out}, 8'd1);
        chk("reset_start_pulse", {7'd0, start_pulse}, 8'd0);
        chk("reset_game_active", {7'd0, game_active}, 8'd0);
        @(posedge clk); #5 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // exact 2-clock latency for pixel and sync
        set_pix(11'd0, 11'd0, 1'b1);
        @(posedge clk); #1 chk("latency_n+1", rgb, 8'h00);
        @(posedge clk); #1 chk("latency_n+2", rgb, TXT);
        @(posedge clk); #2 hsync_in = 1'b0;
        @(posedge clk); #1 chk("hsync_n+1", {7'd0, hsync_out}, 8'd1);
        @(posedge clk); #1 chk("hsync_n+2", {7'd0, hsync_out}, 8'd0);
        #1 hsync_in = 1'b1;

        // window edges and bitmap zero
        pix_check("col255", 11'd255, 11'd0, 1'b1, TXT);
        pix_check("col256", 11'd256, 11'd0, 1'b1, BGC);
        pix_check("row64", 11'd0, 11'd64, 1'b1, BGC);
        pix_check("bit0_pixel", 11'd1, 11'd0, 1'b1, BGC);
        pix_check("disp_off", 11'd0, 11'd0, 1'b0, 8'h00);

        // prompt blink, BF=2
        pix_check("prompt_on", 11'd1, 11'd50, 1'b1, TXT);
        vs_pulse(); #1 chk("blink_1", rgb, TXT);
        vs_pulse(); #1 chk("blink_2", rgb, BGC);
        vs_pulse(); #1 chk("blink_3", rgb, BGC);
        vs_pulse(); #1 chk("blink_4", rgb, TXT);
        pix_check("title_row47", 11'd1, 11'd47, 1'b1, glyph({6'd47, 8'd1}) ? TXT : BGC);

        random_pixels(1500, 1'b0);

        // debounce: short glitch rejected, full press/release starts
        sp_seen = 0;
        key_press(3, 20);
        #1 chk("glitch_active", {7'd0, game_active}, 8'd0);
        chk("glitch_pulses", 8'(sp_seen), 8'd0);
        key_press(10, 10);
        repeat (6) @(posedge clk);
        #1 chk("start_active", {7'd0, game_active}, 8'd1);
        chk("start_pulses", 8'(sp_seen), 8'd1);

        // running: black screen, keys ignored
        random_pixels(200, 1'b1);
        key_press(10, 12);
        #1 chk("run_pulses", 8'(sp_seen), 8'd1);
        chk("run_active", {7'd0, game_active}, 8'd1);
        pix_check("run_black", 11'd0, 11'd0, 1'b1, 8'h00);

        pulse_game_over();
        #1 chk("over_active", {7'd0, game_active}, 8'd0);
        pix_check("over_title", 11'd0, 11'd0, 1'b1, TXT);
        pulse_game_over();
        #1 chk("over_in_title", {7'd0, game_active}, 8'd0);
        pix_check("title_kept", 11'd255, 11'd0, 1'b1, TXT);

        // reset while running
        key_press(10, 10);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (game_active) seen = 1'b1;
        end
        #1 chk("reach_run", {7'd0, seen}, 8'd1);
        @(posedge clk); #2 hsync_in = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rgb", rgb, 8'h00);
        chk("async_hsync", {7'd0, hsync_out}, 8'd1);
        chk("async_active", {7'd0, game_active}, 8'd0);
        repeat (3) @(posedge clk);
        #2 hsync_in = 1'b1;
        #3 rst_n = 1'b1;
        sp_seen = 0;
        repeat (30) @(posedge clk);
        #1 chk("post_rst_pulses", 8'(sp_seen), 8'd0);
        chk("post_rst_active", {7'd0, game_active}, 8'd0);
        chk("post_rst_title", rgb, TXT);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
